// File: rtl/answer_period_ctrl.sv
// answer_period_ctrl: timed answer window with a 1 Hz countdown, grading at
// expiry, and a result hold on the 4-digit active-low 7-segment display.
module answer_period_ctrl #(
  parameter int PERIOD_SECS = 5,
  parameter int HOLD_SECS   = 3,
  parameter int COUNT_W     = 8
) (
  input  logic               Clk100M,
  input  logic               Reset,
  input  logic               Tick1Hz,
  input  logic               answerSig,
  input  logic               abortSig,
  input  logic [COUNT_W-1:0] userCount,
  input  logic [COUNT_W-1:0] targetCount,
  output logic               stopCount,
  output logic               postSig,
  output logic               correct,
  output logic               resultValid,
  output logic               busy,
  output logic [3:0]         secsLeft,
  output logic [31:0]        answerSeg
);

  typedef enum logic [1:0] {IDLE, ANSWER, RESULT} state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_F     = 8'h8E;

  state_t      state, state_nx;
  logic [3:0]  hold_cnt, hold_nx, secs_nx;
  logic        stop_nx, correct_nx, rv_nx, busy_nx;
  logic [6:0]  user_sat;
  logic [3:0]  tens, ones;
  logic [7:0]  dig3;
  logic [31:0] seg_nx;

  // Active-low {dp,g..a} code for a decimal digit; anything else is blank.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hD8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Two display digits only, so the player's count clips at 99.
  function automatic logic [6:0] sat99(input logic [COUNT_W-1:0] v);
    if (v > COUNT_W'(99)) return 7'd99;
    else                  return 7'(v);
  endfunction

  // Next-state and next-output logic; every register's next value starts as a hold.
  always_comb begin
    state_nx   = state;
    secs_nx    = secsLeft;
    hold_nx    = hold_cnt;
    stop_nx    = 1'b0;
    correct_nx = correct;
    rv_nx      = resultValid;
    busy_nx    = busy;
    case (state)
      IDLE: begin
        // A tick arriving with the start request is deliberately not counted.
        if (answerSig) begin
          state_nx = ANSWER;
          secs_nx  = 4'(PERIOD_SECS);
          busy_nx  = 1'b1;
        end
      end
      ANSWER: begin
        if (abortSig) begin
          // Abort beats an expiring tick: no pulses, grade left untouched.
          state_nx = IDLE;
          secs_nx  = 4'd0;
          busy_nx  = 1'b0;
        end else if (Tick1Hz) begin
          if (secsLeft <= 4'd1) begin
            state_nx   = RESULT;
            secs_nx    = 4'd0;
            stop_nx    = 1'b1;
            correct_nx = (userCount == targetCount);
            rv_nx      = 1'b1;
            hold_nx    = 4'(HOLD_SECS);
          end else begin
            secs_nx = secsLeft - 4'd1;
          end
        end
      end
      RESULT: begin
        if (abortSig) begin
          state_nx = IDLE;
          rv_nx    = 1'b0;
          busy_nx  = 1'b0;
        end else if (Tick1Hz) begin
          if (hold_cnt <= 4'd1) begin
            state_nx = IDLE;
            hold_nx  = 4'd0;
            rv_nx    = 1'b0;
            busy_nx  = 1'b0;
          end else begin
            hold_nx = hold_cnt - 4'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        secs_nx  = 4'd0;
        rv_nx    = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // Display image derived from the next state so it tracks the registered state exactly.
  always_comb begin
    user_sat = sat99(userCount);
    tens     = 4'(user_sat / 7'd10);
    ones     = 4'(user_sat % 7'd10);
    dig3     = (state_nx == ANSWER) ? seg7(secs_nx) : (correct_nx ? SEG_C : SEG_F);
    seg_nx   = (state_nx == IDLE) ? 32'hFFFF_FFFF
                                  : {dig3, SEG_BLANK, seg7(ones), seg7(tens)};
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      state       <= IDLE;
      secsLeft    <= 4'd0;
      hold_cnt    <= 4'd0;
      stopCount   <= 1'b0;
      postSig     <= 1'b0;
      correct     <= 1'b0;
      resultValid <= 1'b0;
      busy        <= 1'b0;
      answerSeg   <= 32'hFFFF_FFFF;
    end else begin
      state       <= state_nx;
      secsLeft    <= secs_nx;
      hold_cnt    <= hold_nx;
      stopCount   <= stop_nx;
      postSig     <= stop_nx;
      correct     <= correct_nx;
      resultValid <= rv_nx;
      busy        <= busy_nx;
      answerSeg   <= seg_nx;
    end
  end

endmodule
